// File: rtl/difftest_commit_bridge_pkg.sv
// ============================================================================
// Module   : difftest_commit_bridge_pkg
// Purpose  : Shared constants and state encoding for the commit-trace bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

package difftest_commit_bridge_pkg;

  localparam logic [63:0] c_PC_START       = 64'h0000_0000_8000_0000;
  localparam logic [6:0]  c_TRAP_OPCODE    = 7'h6b;
  localparam logic [7:0]  c_WDOG_TRAP_CODE = 8'hFF;
  localparam logic [4:0]  c_A0_IDX         = 5'd10;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } bridge_state_e;

endpackage

`default_nettype wire

// File: rtl/difftest_commit_bridge_commit_watchdog.sv
// ============================================================================
// Module   : commit_watchdog
// Purpose  : Counts RUN cycles without an accepted commit; flags expiry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module commit_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic accept,
  output logic expire
);

  localparam int c_IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST =
      (TIMEOUT > 0) ? c_IDLE_W'(TIMEOUT - 1) : '0;

  logic [c_IDLE_W-1:0] r_idle;

  // Saturates at the limit so a stalled run flag cannot wrap the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (run) begin
      if (accept)
        r_idle <= '0;
      else if (r_idle != c_IDLE_LAST)
        r_idle <= r_idle + c_IDLE_W'(1);
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog_on
      assign expire = run && !accept && (r_idle == c_IDLE_LAST);
    end else begin : g_wdog_off
      assign expire = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/difftest_commit_bridge.sv
// ============================================================================
// Module   : difftest_commit_bridge
// Purpose  : Registered multi-lane commit capture with trap/watchdog halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module difftest_commit_bridge
  import difftest_commit_bridge_pkg::*;
#(
  parameter int NCOMMIT = 2,
  parameter int XLEN    = 64,
  parameter int CNT_W   = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCOMMIT-1:0]        in_valid,
  input  logic [NCOMMIT*XLEN-1:0]   in_pc,
  input  logic [NCOMMIT*32-1:0]     in_inst,
  input  logic [NCOMMIT-1:0]        in_wen,
  input  logic [NCOMMIT*5-1:0]      in_wdest,
  input  logic [NCOMMIT*XLEN-1:0]   in_wdata,
  input  logic [XLEN-1:0]           in_a0,
  output logic [NCOMMIT-1:0]        out_valid,
  output logic [NCOMMIT*XLEN-1:0]   out_pc,
  output logic [NCOMMIT*32-1:0]     out_inst,
  output logic [NCOMMIT-1:0]        out_wen,
  output logic [NCOMMIT*8-1:0]      out_wdest,
  output logic [NCOMMIT*XLEN-1:0]   out_wdata,
  output logic                      trap_valid,
  output logic [7:0]                trap_code,
  output logic [XLEN-1:0]           trap_pc,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          instr_cnt,
  output logic                      halted
);

  localparam int c_POP_W = $clog2(NCOMMIT + 1);

  bridge_state_e        r_state;
  bridge_state_e        w_state_nxt;
  logic [XLEN-1:0]      r_last_pc;
  logic [NCOMMIT-1:0]   w_live;
  logic [NCOMMIT-1:0]   w_accept;
  logic                 w_trap_hit;
  logic [XLEN-1:0]      w_trap_pc;
  logic [7:0]           w_trap_code;
  logic [XLEN-1:0]      w_last_pc_nxt;
  logic [c_POP_W-1:0]   w_pop;
  logic [NCOMMIT*8-1:0] w_wdest_ext;
  logic                 w_run;
  logic                 w_expire;

  assign w_run  = (r_state == ST_RUN);
  assign halted = (r_state == ST_HALT);

  // Walk lanes oldest-first: the first trap closes the window, and the last
  // x10 writer seen before it supplies the forwarded trap code.
  always_comb begin
    w_live        = '0;
    w_accept      = '0;
    w_trap_hit    = 1'b0;
    w_trap_pc     = '0;
    w_trap_code   = in_a0[7:0];
    w_last_pc_nxt = r_last_pc;
    w_pop         = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      w_live[i] = in_valid[i] &&
                  !((in_pc[i*XLEN +: XLEN] == XLEN'(c_PC_START)) &&
                    (in_inst[i*32 +: 32] == 32'd0));
      if (w_live[i] && !w_trap_hit) begin
        w_accept[i]   = 1'b1;
        w_pop         = w_pop + c_POP_W'(1);
        w_last_pc_nxt = in_pc[i*XLEN +: XLEN];
        if (in_inst[i*32 +: 7] == c_TRAP_OPCODE) begin
          w_trap_hit = 1'b1;
          w_trap_pc  = in_pc[i*XLEN +: XLEN];
        end else if (in_wen[i] && (in_wdest[i*5 +: 5] == c_A0_IDX)) begin
          w_trap_code = in_wdata[i*XLEN +: 8];
        end
      end
    end
  end

  always_comb begin
    w_wdest_ext = '0;
    for (int i = 0; i < NCOMMIT; i++)
      w_wdest_ext[i*8 +: 8] = {3'd0, in_wdest[i*5 +: 5]};
  end

  commit_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (w_run),
    .accept (|w_accept),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_RUN;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_RUN) && (w_trap_hit || w_expire))
      w_state_nxt = ST_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= '0;
      out_pc     <= '0;
      out_inst   <= '0;
      out_wen    <= '0;
      out_wdest  <= '0;
      out_wdata  <= '0;
      trap_valid <= 1'b0;
      trap_code  <= '0;
      trap_pc    <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      r_last_pc  <= '0;
    end else if (w_run) begin
      out_valid <= w_accept;
      out_pc    <= in_pc;
      out_inst  <= in_inst;
      out_wen   <= in_wen;
      out_wdest <= w_wdest_ext;
      out_wdata <= in_wdata;
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      instr_cnt <= instr_cnt + CNT_W'(w_pop);
      if (|w_accept)
        r_last_pc <= w_last_pc_nxt;
      // A trapping cycle always has an accept, so it cannot also expire.
      if (w_trap_hit) begin
        trap_valid <= 1'b1;
        trap_code  <= w_trap_code;
        trap_pc    <= w_trap_pc;
      end else if (w_expire) begin
        trap_valid <= 1'b1;
        trap_code  <= c_WDOG_TRAP_CODE;
        trap_pc    <= r_last_pc;
      end
    end else begin
      out_valid <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_difftest_commit_bridge.sv
// ============================================================================
// Module   : tb_difftest_commit_bridge
// Purpose  : Directed self-checking bench for the commit-trace bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_difftest_commit_bridge;

  localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] TRAP     = 32'h0000_006b;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   in_valid;
  logic [127:0] in_pc;
  logic [63:0]  in_inst;
  logic [1:0]   in_wen;
  logic [9:0]   in_wdest;
  logic [127:0] in_wdata;
  logic [63:0]  in_a0;

  logic [1:0]   b_valid, s_valid;
  logic [127:0] b_pc, s_pc;
  logic [63:0]  b_inst, s_inst;
  logic [1:0]   b_wen, s_wen;
  logic [15:0]  b_wdest, s_wdest;
  logic [127:0] b_wdata, s_wdata;
  logic         b_trap, s_trap;
  logic [7:0]   b_code, s_code;
  logic [63:0]  b_tpc, s_tpc;
  logic [63:0]  b_cyc, b_ins;
  logic [3:0]   s_cyc, s_ins;
  logic         b_halt, s_halt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  difftest_commit_bridge #(
    .NCOMMIT (2), .XLEN (64), .CNT_W (64), .TIMEOUT (8)
  ) u_dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_pc (in_pc), .in_inst (in_inst),
    .in_wen (in_wen), .in_wdest (in_wdest), .in_wdata (in_wdata), .in_a0 (in_a0),
    .out_valid (b_valid), .out_pc (b_pc), .out_inst (b_inst), .out_wen (b_wen),
    .out_wdest (b_wdest), .out_wdata (b_wdata),
    .trap_valid (b_trap), .trap_code (b_code), .trap_pc (b_tpc),
    .cycle_cnt (b_cyc), .instr_cnt (b_ins), .halted (b_halt)
  );

  difftest_commit_bridge #(
    .NCOMMIT (2), .XLEN (64), .CNT_W (4), .TIMEOUT (0)
  ) u_dut_small (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_pc (in_pc), .in_inst (in_inst),
    .in_wen (in_wen), .in_wdest (in_wdest), .in_wdata (in_wdata), .in_a0 (in_a0),
    .out_valid (s_valid), .out_pc (s_pc), .out_inst (s_inst), .out_wen (s_wen),
    .out_wdest (s_wdest), .out_wdata (s_wdata),
    .trap_valid (s_trap), .trap_code (s_code), .trap_pc (s_tpc),
    .cycle_cnt (s_cyc), .instr_cnt (s_ins), .halted (s_halt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = '0; in_pc = '0; in_inst = '0; in_wen = '0;
    in_wdest = '0; in_wdata = '0; in_a0 = '0;
  endtask

  task automatic set_lane(input int i, input logic [63:0] pc, input logic [31:0] inst,
                          input logic wen, input logic [4:0] wd, input logic [63:0] wdat);
    in_valid[i]        = 1'b1;
    in_pc[i*64 +: 64]  = pc;
    in_inst[i*32 +: 32] = inst;
    in_wen[i]          = wen;
    in_wdest[i*5 +: 5] = wd;
    in_wdata[i*64 +: 64] = wdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    tick();
    tick();
    chk("rst_out_valid", b_valid, 0);
    chk("rst_trap_valid", b_trap, 0);
    chk("rst_halted", b_halt, 0);
    chk("rst_cycle", b_cyc, 0);
    chk("rst_instr", b_ins, 0);
    chk("rst_trap_code", b_code, 0);
    chk("rst_trap_pc", b_tpc, 0);
    chk("rst_out_pc", b_pc, 0);
    rst_n = 1'b1;

    // Counter wrap on the 4-bit instance
    for (int k = 0; k < 16; k++) begin
      clear_in();
      set_lane(0, 64'h8000_0100 + 64'(4 * k), NOP, 1'b0, 5'd0, 64'd0);
      tick();
    end
    chk("wrap_small_instr", s_ins, 0);
    chk("wrap_small_cycle", s_cyc, 0);
    chk("wrap_big_instr", b_ins, 16);
    chk("wrap_big_cycle", b_cyc, 16);
    chk("wrap_out_valid", b_valid, 2'b01);
    chk("wrap_out_pc0", b_pc[63:0], 64'h8000_013c);
    clear_in();
    set_lane(0, 64'h8000_0140, NOP, 1'b0, 5'd0, 64'd0);
    tick();
    chk("wrap_small_instr_1", s_ins, 1);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cycle", b_cyc, 0);
    chk("arst_instr", b_ins, 0);
    chk("arst_out_valid", b_valid, 0);
    chk("arst_out_pc", b_pc, 0);
    chk("arst_small_instr", s_ins, 0);
    clear_in();
    tick();
    rst_n = 1'b1;

    // Both lanes live for 10 cycles
    for (int k = 0; k < 10; k++) begin
      clear_in();
      set_lane(0, 64'h8000_1000 + 64'(8 * k), 32'h00a0_0093, 1'b1, 5'd3, 64'h1000 + 64'(k));
      set_lane(1, 64'h8000_1004 + 64'(8 * k), 32'h0010_0113, 1'b1, 5'd31,
               64'hffff_0000_0000_0000 | 64'(k));
      tick();
      chk("dual_pc0", b_pc[63:0], 64'h8000_1000 + 64'(8 * k));
      chk("dual_pc1", b_pc[127:64], 64'h8000_1004 + 64'(8 * k));
      chk("dual_wdata1", b_wdata[127:64], 64'hffff_0000_0000_0000 | 64'(k));
    end
    chk("dual_instr", b_ins, 20);
    chk("dual_cycle", b_cyc, 10);
    chk("dual_valid", b_valid, 2'b11);
    chk("dual_wen", b_wen, 2'b11);
    chk("dual_wdest0", b_wdest[7:0], 8'h03);
    chk("dual_wdest1", b_wdest[15:8], 8'h1f);
    chk("dual_inst0", b_inst[31:0], 32'h00a0_0093);

    // Bubble on lane 0
    clear_in();
    set_lane(0, PC_START, 32'd0, 1'b1, 5'd10, 64'h99);
    set_lane(1, 64'h8000_2000, NOP, 1'b0, 5'd0, 64'd0);
    tick();
    chk("bub_valid", b_valid, 2'b10);
    chk("bub_instr", b_ins, 21);
    chk("bub_cycle", b_cyc, 11);
    chk("bub_pc1", b_pc[127:64], 64'h8000_2000);
    chk("bub_no_trap", b_trap, 0);

    // Trap on lane 1 with a0 forwarded from lane 0
    clear_in();
    in_a0 = 64'h5;
    set_lane(0, 64'h8000_21fc, 32'h0370_0513, 1'b1, 5'd10, 64'h37);
    set_lane(1, 64'h8000_2200, TRAP, 1'b0, 5'd0, 64'd0);
    tick();
    chk("trap1_valid", b_trap, 1);
    chk("trap1_halted", b_halt, 1);
    chk("trap1_out_valid", b_valid, 2'b11);
    chk("trap1_code", b_code, 8'h37);
    chk("trap1_pc", b_tpc, 64'h8000_2200);
    chk("trap1_instr", b_ins, 23);
    chk("trap1_cycle", b_cyc, 12);
    clear_in();
    set_lane(0, 64'h8000_2204, NOP, 1'b0, 5'd0, 64'd0);
    tick();
    chk("trap1_halt_valid", b_valid, 0);
    chk("trap1_halt_cycle", b_cyc, 12);
    chk("trap1_halt_instr", b_ins, 23);
    chk("trap1_halt_code", b_code, 8'h37);

    // Trap on lane 0; lane 1 dropped, outputs frozen afterwards
    do_reset();
    clear_in();
    in_a0 = 64'h42;
    set_lane(0, 64'h8000_3000, TRAP, 1'b0, 5'd0, 64'd0);
    set_lane(1, 64'h8000_3004, NOP, 1'b1, 5'd10, 64'h99);
    tick();
    chk("trap0_out_valid", b_valid, 2'b01);
    chk("trap0_instr", b_ins, 1);
    chk("trap0_cycle", b_cyc, 1);
    chk("trap0_code", b_code, 8'h42);
    chk("trap0_pc", b_tpc, 64'h8000_3000);
    chk("trap0_halted", b_halt, 1);
    for (int k = 0; k < 20; k++) begin
      clear_in();
      set_lane(0, 64'h8000_4000 + 64'(4 * k), NOP, 1'b1, 5'd10, 64'(k));
      set_lane(1, 64'h8000_4800 + 64'(4 * k), TRAP, 1'b0, 5'd0, 64'd0);
      tick();
      chk("frz_valid", b_valid, 0);
      chk("frz_cycle", b_cyc, 1);
      chk("frz_instr", b_ins, 1);
      chk("frz_pc0", b_pc[63:0], 64'h8000_3000);
      chk("frz_code", b_code, 8'h42);
      chk("frz_tpc", b_tpc, 64'h8000_3000);
    end

    // Watchdog after one accept
    do_reset();
    clear_in();
    set_lane(0, 64'h8000_0010, NOP, 1'b0, 5'd0, 64'd0);
    tick();
    clear_in();
    chk("wd1_cycle", b_cyc, 1);
    chk("wd1_instr", b_ins, 1);
    repeat (7) tick();
    chk("wd1_not_yet", b_halt, 0);
    chk("wd1_trap_not_yet", b_trap, 0);
    tick();
    chk("wd1_trap_valid", b_trap, 1);
    chk("wd1_halted", b_halt, 1);
    chk("wd1_code", b_code, 8'hff);
    chk("wd1_pc", b_tpc, 64'h8000_0010);
    chk("wd1_cycle_end", b_cyc, 9);

    // Watchdog from reset with no commits at all
    do_reset();
    repeat (7) tick();
    chk("wd0_not_yet", b_halt, 0);
    tick();
    chk("wd0_halted", b_halt, 1);
    chk("wd0_cycle", b_cyc, 8);
    chk("wd0_pc", b_tpc, 0);
    chk("wd0_code", b_code, 8'hff);
    chk("wd0_disabled_small", s_halt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
